// File: rtl/ps2_game_keys.sv
// PS/2 keyboard front end: pin sync, clock glitch filter, 11-bit frame receiver
// and E0/F0 make/break decoder producing the game's duck/jump/restart controls.
module ps2_game_keys #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_low,
  output logic       key_jump,
  output logic       key_restart,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] K_S = 3'd0, K_DN = 3'd1, K_SP = 3'd2, K_W = 3'd3,
                         K_UP = 3'd4, K_ENT = 3'd5, K_R = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          filt, filt_q, fall;
  logic [FW-1:0] filt_cnt;
  state_t        state, state_n;
  logic [3:0]    bitcnt;
  logic [9:0]    sr;
  logic [TW-1:0] to_cnt;
  logic          timeout, frame_ok;
  logic [7:0]    code_q;
  logic          ext, brk;
  logic [6:0]    held;
  logic          key_hit;
  logic [2:0]    key_idx;

  // Sync + filter: filtered level follows only after FILTER_LEN disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q   <= filt;
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = filt_q & ~filt;
  assign frame_ok = (^sr[7:0] ^ sr[8]) & sr[9];
  assign timeout  = (state == SHIFT) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n    = state;
    scan_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE:  if (fall && !dat_sync[1]) state_n = SHIFT;
      SHIFT: begin
        if (fall && bitcnt == 4'd9) state_n = CHECK;
        else if (timeout) begin
          frame_err = 1'b1;
          state_n   = IDLE;
        end
      end
      CHECK: begin
        state_n    = IDLE;
        scan_valid = frame_ok;
        frame_err  = ~frame_ok;
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame bits shift in from the top, so after ten samples sr = {stop, parity, data}.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      sr     <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == SHIFT) begin
        if (fall) begin
          sr     <= {dat_sync[1], sr[9:1]};
          bitcnt <= bitcnt + 1'b1;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        bitcnt <= '0;
        to_cnt <= '0;
      end
    end
  end

  assign scan_code = scan_valid ? sr[7:0] : code_q;

  always_comb begin
    key_hit = 1'b1;
    key_idx = K_S;
    case ({ext, sr[7:0]})
      9'h01B:  key_idx = K_S;
      9'h172:  key_idx = K_DN;
      9'h029:  key_idx = K_SP;
      9'h01D:  key_idx = K_W;
      9'h175:  key_idx = K_UP;
      9'h05A:  key_idx = K_ENT;
      9'h02D:  key_idx = K_R;
      default: key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q      <= 8'h00;
      ext         <= 1'b0;
      brk         <= 1'b0;
      held        <= '0;
      key_restart <= 1'b0;
    end else begin
      key_restart <= 1'b0;
      if (scan_valid) begin
        code_q <= sr[7:0];
        if (sr[7:0] == 8'hE0) ext <= 1'b1;
        else if (sr[7:0] == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (key_hit) begin
            held[key_idx] <= ~brk;
            // Only a fresh press restarts; typematic repeats find the bit already set.
            if (!brk && !held[key_idx] && (key_idx == K_ENT || key_idx == K_R))
              key_restart <= 1'b1;
          end
        end
      end
      if (timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign key_low  = held[K_S] | held[K_DN];
  assign key_jump = held[K_SP] | held[K_W] | held[K_UP];
endmodule

// File: tb/tb_ps2_game_keys.sv
// Randomized bench for ps2_game_keys against a byte-level keyboard model.
module tb_ps2_game_keys;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       key_low, key_jump, key_restart, scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_game_keys #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_low(key_low), .key_jump(key_jump), .key_restart(key_restart),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  int sv_cnt = 0, fe_cnt = 0, rs_cnt = 0, wide_cnt = 0, sv_cyc = 0, fe_cyc = 0;
  logic [7:0] sv_code = 8'h00;
  logic sv_prev = 1'b0, fe_prev = 1'b0, rs_prev = 1'b0;
  always @(negedge clk) begin
    if (scan_valid) begin sv_cnt++; sv_code = scan_code; sv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (key_restart) rs_cnt++;
    if ((scan_valid && sv_prev) || (frame_err && fe_prev) || (key_restart && rs_prev)) wide_cnt++;
    sv_prev = scan_valid; fe_prev = frame_err; rs_prev = key_restart;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Keyboard model: named keys, make/break from the byte stream.
  bit       m_ext, m_brk;
  bit [6:0] m_held;   // s, dn, sp, w, up, ent, r
  int       m_rs;

  function automatic int kmap(input bit e, input logic [7:0] c);
    if (!e && c == 8'h1B) return 0;
    if ( e && c == 8'h72) return 1;
    if (!e && c == 8'h29) return 2;
    if (!e && c == 8'h1D) return 3;
    if ( e && c == 8'h75) return 4;
    if (!e && c == 8'h5A) return 5;
    if (!e && c == 8'h2D) return 6;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = kmap(m_ext, b);
      if (k >= 0) begin
        if (!m_brk && !m_held[k] && (k == 5 || k == 6)) m_rs++;
        m_held[k] = !m_brk;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int last_fall = 0, ref_lat = 0;

  task automatic ps2_bit(input bit b);
    @(negedge clk) ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0; last_fall = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad);
    ps2_bit(1'b1);
  endtask

  task automatic check_keys(input string tag);
    chk({tag, ".low"}, 32'(key_low), 32'(m_held[0] | m_held[1]));
    chk({tag, ".jump"}, 32'(key_jump), 32'(m_held[2] | m_held[3] | m_held[4]));
    chk({tag, ".restart"}, 32'(rs_cnt), 32'(m_rs));
  endtask

  task automatic send_key(input logic [7:0] b, input bit bad);
    int sv0, fe0, lat;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(b, bad);
    wait_cyc(HALF);
    if (!bad) begin
      lat = sv_cyc - last_fall;
      chk("sv_count", 32'(sv_cnt - sv0), 32'd1);
      chk("scan_code", 32'(sv_code), 32'(b));
      chk("latency", 32'(lat >= FL + 2 && lat <= FL + 5), 32'd1);
      if (ref_lat == 0) ref_lat = lat;
      model_byte(b);
    end else begin
      chk("fe_count", 32'(fe_cnt - fe0), 32'd1);
      chk("sv_none", 32'(sv_cnt - sv0), 32'd0);
    end
    check_keys("keys");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  logic [7:0] pool [12] = '{8'h29, 8'h1D, 8'h1B, 8'h72, 8'h75, 8'h5A,
                            8'h2D, 8'hE0, 8'hF0, 8'hE1, 8'h13, 8'h5A};
  logic [7:0] b29 = 8'h29;

  initial begin
    int sv0, fe0, rs0;
    model_reset(); m_rs = 0;
    wait_cyc(5);
    chk("rst.low", 32'(key_low), 0);
    chk("rst.jump", 32'(key_jump), 0);
    chk("rst.code", 32'(scan_code), 0);
    chk("rst.pulses", 32'(sv_cnt + fe_cnt + rs_cnt), 0);
    rst = 1'b0;

    // Reset after start + 5 data bits discards the partial byte
    sv0 = sv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b29[i]);
    @(negedge clk) rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(HALF);
    chk("midrst.outs", 32'({key_low, key_jump, key_restart, scan_code}), 0);
    chk("midrst.pulses", 32'((sv_cnt - sv0) + (fe_cnt - fe0)), 0);

    send_key(8'h29, 0);
    send_key(8'hF0, 0); send_key(8'h29, 0);
    chk("jump.released", 32'(key_jump), 0);

    // Two duck keys are independent
    send_key(8'hE0, 0); send_key(8'h72, 0);
    send_key(8'h1B, 0);
    send_key(8'hE0, 0); send_key(8'hF0, 0); send_key(8'h72, 0);
    chk("low.still_held", 32'(key_low), 1);
    send_key(8'hF0, 0); send_key(8'h1B, 0);
    chk("low.released", 32'(key_low), 0);
    rs0 = rs_cnt;
    send_key(8'hE0, 0); send_key(8'h5A, 0);
    chk("kp_enter.no_pulse", 32'(rs_cnt - rs0), 0);

    // Typematic Enter then re-press
    rs0 = rs_cnt;
    send_key(8'h5A, 0); send_key(8'h5A, 0); send_key(8'h5A, 0);
    chk("typematic.one", 32'(rs_cnt - rs0), 1);
    send_key(8'hF0, 0); send_key(8'h5A, 0); send_key(8'h5A, 0);
    chk("typematic.two", 32'(rs_cnt - rs0), 2);

    send_key(8'h29, 1);
    chk("badpar.jump", 32'(key_jump), 0);

    // Timeout after E0 and a partial frame; flags cleared, FSM back to IDLE
    send_key(8'hE0, 0);
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    wait_cyc(TO + 400 - HALF);
    chk("timeout.err", 32'(fe_cnt - fe0), 1);
    chk("timeout.when", 32'(fe_cyc - last_fall), 32'(TO + ref_lat - 1));
    m_ext = 0; m_brk = 0;
    send_key(8'h75, 0);
    chk("timeout.ext_cleared", 32'(key_jump), 0);
    send_key(8'h1D, 0);
    chk("after_timeout.jump", 32'(key_jump), 1);

    // 3-cycle clock glitch with data low must not start a frame
    sv0 = sv_cnt; fe0 = fe_cnt;
    @(negedge clk) ps2_data = 1'b0; ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(4 * HALF);
    chk("glitch.pulses", 32'((sv_cnt - sv0) + (fe_cnt - fe0)), 0);
    send_key(8'hF0, 0); send_key(8'h1D, 0);

    for (int n = 0; n < 40; n++)
      send_key(pool[$urandom_range(0, 11)], $urandom_range(0, 9) == 0);

    chk("pulse_width", 32'(wide_cnt), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
